cmd_response_tx: RTL and testbench

- Transmit side of the command byte link. Drives the cmd_out byte stream that the command decoder currently ties off.
- Collects response requests from the command decoder and the error reports it raises, and queues them in a small FIFO.
- Serializes each request into a framed byte sequence (opcode byte, then payload) toward the host link.

---
 rtl/cmd_response_tx.sv | 173 +++++++++++++++++
 tb/tb_cmd_response_tx.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_response_tx.sv
// Transmit side of the command byte link: queues response and error requests
// and serializes each one as an opcode byte followed by its payload bytes.
module cmd_response_tx #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STATUS_BYTES = 4
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        rsp_valid,
  output logic                        rsp_ready,
  input  logic [1:0]                  rsp_kind,
  input  logic [7:0]                  rsp_arg,
  input  logic [8*STATUS_BYTES-1:0]   rsp_status,
  input  logic                        err_valid,
  input  logic [7:0]                  err_code,
  output logic                        tx_valid,
  input  logic                        tx_ready,
  output logic [7:0]                  tx_data,
  output logic [7:0]                  drop_count,
  output logic [$clog2(DEPTH):0]      fifo_level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned SW = 8 * STATUS_BYTES;
  localparam int unsigned CW = (STATUS_BYTES > 1) ? $clog2(STATUS_BYTES) : 1;

  localparam logic [1:0] K_ACK    = 2'd0;
  localparam logic [1:0] K_ERR    = 2'd1;
  localparam logic [1:0] K_STATUS = 2'd2;
  localparam logic [1:0] K_NOP    = 2'd3;

  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} state_t;

  logic [1:0]    kind_mem   [DEPTH];
  logic [7:0]    arg_mem    [DEPTH];
  logic [SW-1:0] status_mem [DEPTH];

  logic [LW-1:0] wr_ptr, rd_ptr, level;
  logic          full, empty;
  logic          push_err, push_rsp, push, drop, pop;
  logic [1:0]    wr_kind;
  logic [7:0]    wr_arg;

  state_t        state, state_n;
  logic [1:0]    kind_q, kind_n;
  logic [7:0]    arg_q, arg_n;
  logic [SW-1:0] status_q, status_n;
  logic [CW-1:0] byte_cnt, cnt_n;
  logic          tx_valid_n;
  logic [7:0]    tx_data_n;

  function automatic logic [7:0] opcode(input logic [1:0] kind);
    case (kind)
      K_ACK:    opcode = 8'hC0;
      K_ERR:    opcode = 8'hE0;
      K_STATUS: opcode = 8'hD0;
      default:  opcode = 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] status_byte(input logic [SW-1:0] s, input logic [CW-1:0] idx);
    status_byte = 8'h00;
    for (int unsigned i = 0; i < STATUS_BYTES; i++) begin
      if (idx == CW'(i)) status_byte = s[8*i +: 8];
    end
  endfunction

  // Error reports win the single write port; a full FIFO drops them and counts the loss.
  assign level      = wr_ptr - rd_ptr;
  assign full       = (level == LW'(DEPTH));
  assign empty      = (level == '0);
  assign push_err   = err_valid && !full;
  assign drop       = err_valid && full;
  assign rsp_ready  = !full && !err_valid;
  assign push_rsp   = rsp_valid && rsp_ready;
  assign push       = push_err || push_rsp;
  assign wr_kind    = push_err ? K_ERR : rsp_kind;
  assign wr_arg     = push_err ? err_code : rsp_arg;
  assign fifo_level = level;

  always_ff @(posedge clk) begin
    if (push) begin
      kind_mem[wr_ptr[AW-1:0]]   <= wr_kind;
      arg_mem[wr_ptr[AW-1:0]]    <= wr_arg;
      status_mem[wr_ptr[AW-1:0]] <= rsp_status;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      drop_count <= 8'd0;
    end else begin
      wr_ptr <= wr_ptr + LW'(push);
      rd_ptr <= rd_ptr + LW'(pop);
      if (drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      kind_q   <= K_NOP;
      arg_q    <= 8'd0;
      status_q <= '0;
      byte_cnt <= '0;
      tx_valid <= 1'b0;
      tx_data  <= 8'd0;
    end else begin
      state    <= state_n;
      kind_q   <= kind_n;
      arg_q    <= arg_n;
      status_q <= status_n;
      byte_cnt <= cnt_n;
      tx_valid <= tx_valid_n;
      tx_data  <= tx_data_n;
    end
  end

  // byte_cnt holds the number of payload bytes still to follow the one on tx_data.
  always_comb begin
    state_n    = state;
    kind_n     = kind_q;
    arg_n      = arg_q;
    status_n   = status_q;
    cnt_n      = byte_cnt;
    tx_valid_n = tx_valid;
    tx_data_n  = tx_data;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          kind_n   = kind_mem[rd_ptr[AW-1:0]];
          arg_n    = arg_mem[rd_ptr[AW-1:0]];
          status_n = status_mem[rd_ptr[AW-1:0]];
          if (kind_n != K_NOP) begin
            state_n    = HEADER;
            tx_valid_n = 1'b1;
            tx_data_n  = opcode(kind_n);
          end
        end
      end
      HEADER: begin
        if (tx_ready) begin
          state_n = PAYLOAD;
          if (kind_q == K_STATUS) begin
            cnt_n     = CW'(STATUS_BYTES - 1);
            tx_data_n = status_byte(status_q, CW'(STATUS_BYTES - 1));
          end else begin
            cnt_n     = '0;
            tx_data_n = arg_q;
          end
        end
      end
      PAYLOAD: begin
        if (tx_ready) begin
          if (byte_cnt == '0) begin
            state_n    = IDLE;
            tx_valid_n = 1'b0;
          end else begin
            cnt_n     = byte_cnt - CW'(1);
            tx_data_n = status_byte(status_q, cnt_n);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cmd_response_tx.sv
// Randomized and directed bench for cmd_response_tx; expected byte stream is
// built from the frame format rules as requests are accepted.
module tb_cmd_response_tx;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned SB    = 4;
  localparam int unsigned SW    = 8 * SB;

  logic          clk, rstn;
  logic          rsp_valid, rsp_ready;
  logic [1:0]    rsp_kind;
  logic [7:0]    rsp_arg;
  logic [SW-1:0] rsp_status;
  logic          err_valid;
  logic [7:0]    err_code;
  logic          tx_valid, tx_ready;
  logic [7:0]    tx_data, drop_count;
  logic [$clog2(DEPTH):0] fifo_level;

  cmd_response_tx #(.DEPTH(DEPTH), .STATUS_BYTES(SB)) dut (
    .clk(clk), .rstn(rstn), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_kind(rsp_kind), .rsp_arg(rsp_arg), .rsp_status(rsp_status),
    .err_valid(err_valid), .err_code(err_code), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_data(tx_data), .drop_count(drop_count),
    .fifo_level(fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int ready_mode = 1;
  int pat = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int got_t[$];

  always @(posedge clk) cyc++;

  // Downstream ready: 0 stalled, 1 open, 2 random, 3 repeating 1,0,0.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: tx_ready = 1'b0;
      1: tx_ready = 1'b1;
      2: tx_ready = 1'($urandom_range(0, 1));
      default: begin tx_ready = (pat % 3 == 0); pat++; end
    endcase
  end

  logic pv = 1'b0, pr = 1'b0;
  logic [7:0] pd = 8'h00;
  always @(negedge clk) begin
    if (!rstn) begin
      pv = 1'b0;
    end else begin
      if (pv && !pr) begin
        n_total++;
        if (tx_valid !== 1'b1 || tx_data !== pd)
          $display("FAIL hold_stable: tx_valid=%b tx_data=%02h, required 1/%02h", tx_valid, tx_data, pd);
        else n_pass++;
      end
      if (tx_valid && tx_ready) begin
        got_q.push_back(tx_data);
        got_t.push_back(cyc);
      end
      pv = tx_valid; pr = tx_ready; pd = tx_data;
    end
  end

  task automatic cycle();
    @(posedge clk); #1;
  endtask

  task automatic model_push(input logic [1:0] k, input logic [7:0] a, input logic [SW-1:0] s);
    case (k)
      2'd0: begin exp_q.push_back(8'hC0); exp_q.push_back(a); end
      2'd1: begin exp_q.push_back(8'hE0); exp_q.push_back(a); end
      2'd2: begin
        exp_q.push_back(8'hD0);
        for (int i = SB - 1; i >= 0; i--) exp_q.push_back(s[8*i +: 8]);
      end
      default: ;
    endcase
  endtask

  task automatic send_rsp(input logic [1:0] k, input logic [7:0] a, input logic [SW-1:0] s);
    logic acc;
    acc = 1'b0;
    rsp_valid = 1'b1; rsp_kind = k; rsp_arg = a; rsp_status = s;
    for (int i = 0; i < 500 && !acc; i++) begin
      @(negedge clk); acc = rsp_ready;
      cycle();
    end
    rsp_valid = 1'b0;
    n_total++;
    if (!acc) $display("FAIL send_accept: kind=%0d arg=%02h never accepted, required acceptance", k, a);
    else begin n_pass++; model_push(k, a, s); end
  endtask

  task automatic finish_check(input string name);
    int t;
    int n;
    t = 0;
    while (got_q.size() < exp_q.size() && t < 3000) begin cycle(); t++; end
    repeat (10) cycle();
    n_total++;
    if (got_q.size() != exp_q.size())
      $display("FAIL %s_count: got %0d bytes, required %0d", name, got_q.size(), exp_q.size());
    else n_pass++;
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      n_total++;
      if (got_q[i] !== exp_q[i])
        $display("FAIL %s_byte%0d: got %02h, required %02h", name, i, got_q[i], exp_q[i]);
      else n_pass++;
    end
    got_q.delete(); exp_q.delete(); got_t.delete();
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) cycle();
    n_total++; if (tx_valid !== 1'b0) $display("FAIL reset_tx_valid: got %b, required 0", tx_valid); else n_pass++;
    n_total++; if (tx_data !== 8'h00) $display("FAIL reset_tx_data: got %02h, required 00", tx_data); else n_pass++;
    n_total++; if (drop_count !== 8'h00) $display("FAIL reset_drop: got %0d, required 0", drop_count); else n_pass++;
    n_total++; if (fifo_level !== 3'd0) $display("FAIL reset_level: got %0d, required 0", fifo_level); else n_pass++;
    n_total++; if (rsp_ready !== 1'b1) $display("FAIL reset_rsp_ready: got %b, required 1", rsp_ready); else n_pass++;
    rstn = 1'b1;
    cycle();
  endtask

  task automatic test_ack();
    ready_mode = 1;
    send_rsp(2'd0, 8'hA1, '0);
    @(negedge clk);
    n_total++; if (tx_valid !== 1'b0 || fifo_level !== 3'd1)
      $display("FAIL ack_queued: tx_valid=%b level=%0d, required 0/1", tx_valid, fifo_level); else n_pass++;
    cycle();
    @(negedge clk);
    n_total++; if (tx_valid !== 1'b1 || tx_data !== 8'hC0 || fifo_level !== 3'd0)
      $display("FAIL ack_header: tx_valid=%b data=%02h level=%0d, required 1/C0/0", tx_valid, tx_data, fifo_level); else n_pass++;
    cycle();
    finish_check("ack");
    n_total++; if (tx_valid !== 1'b0 || fifo_level !== 3'd0)
      $display("FAIL ack_idle: tx_valid=%b level=%0d, required 0/0", tx_valid, fifo_level); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int t;
    ready_mode = 1;
    send_rsp(2'd0, 8'h41, '0);
    send_rsp(2'd0, 8'h42, '0);
    t = 0;
    while (got_q.size() < 4 && t < 200) begin cycle(); t++; end
    n_total++;
    if (got_q.size() < 4) $display("FAIL b2b_timing: got %0d bytes, required 4", got_q.size());
    else if (got_t[1] - got_t[0] != 1 || got_t[2] - got_t[1] != 2)
      $display("FAIL b2b_timing: gaps %0d,%0d, required 1,2", got_t[1] - got_t[0], got_t[2] - got_t[1]);
    else n_pass++;
    finish_check("b2b");
  endtask

  task automatic test_status_backpressure();
    ready_mode = 3;
    send_rsp(2'd2, 8'h00, SW'(32'h11223344));
    finish_check("status_bp");
    ready_mode = 1;
  endtask

  task automatic test_full_drop();
    ready_mode = 0;
    cycle();
    for (int i = 1; i <= 5; i++) send_rsp(2'd0, 8'(i), '0);
    @(negedge clk);
    n_total++; if (rsp_ready !== 1'b0 || fifo_level !== 3'd4)
      $display("FAIL full_state: rsp_ready=%b level=%0d, required 0/4", rsp_ready, fifo_level); else n_pass++;
    cycle();
    err_valid = 1'b1; err_code = 8'h55;
    cycle();
    err_valid = 1'b0;
    @(negedge clk);
    n_total++; if (drop_count !== 8'd1) $display("FAIL drop_one: got %0d, required 1", drop_count); else n_pass++;
    cycle();
    ready_mode = 1;
    finish_check("full_drain");
  endtask

  task automatic test_collision();
    ready_mode = 1;
    err_valid = 1'b1; err_code = 8'h7F;
    rsp_valid = 1'b1; rsp_kind = 2'd0; rsp_arg = 8'h20; rsp_status = '0;
    @(negedge clk);
    n_total++; if (rsp_ready !== 1'b0) $display("FAIL collide_block: rsp_ready=%b, required 0", rsp_ready); else n_pass++;
    cycle();
    err_valid = 1'b0;
    @(negedge clk);
    n_total++; if (rsp_ready !== 1'b1) $display("FAIL collide_accept: rsp_ready=%b, required 1", rsp_ready); else n_pass++;
    cycle();
    rsp_valid = 1'b0;
    model_push(2'd1, 8'h7F, '0);
    model_push(2'd0, 8'h20, '0);
    finish_check("collide");
  endtask

  task automatic test_nop_saturation();
    ready_mode = 1;
    send_rsp(2'd0, 8'h31, '0);
    send_rsp(2'd3, 8'h99, '0);
    send_rsp(2'd0, 8'h32, '0);
    finish_check("nop");
    ready_mode = 0;
    cycle();
    for (int i = 0; i < 5; i++) send_rsp(2'd0, 8'(8'h61 + i), '0);
    err_valid = 1'b1; err_code = 8'hAA;
    repeat (300) cycle();
    err_valid = 1'b0;
    @(negedge clk);
    n_total++; if (drop_count !== 8'd255) $display("FAIL drop_sat: got %0d, required 255", drop_count); else n_pass++;
    cycle();
    ready_mode = 1;
    finish_check("sat_drain");
  endtask

  task automatic test_random();
    logic [SW-1:0] s;
    ready_mode = 2;
    repeat (40) begin
      for (int b = 0; b < SB; b++) s[8*b +: 8] = 8'($urandom);
      send_rsp(2'($urandom_range(0, 3)), 8'($urandom), s);
      repeat ($urandom_range(0, 3)) cycle();
    end
    finish_check("random");
    ready_mode = 1;
  endtask

  task automatic test_reset_midframe();
    int t;
    ready_mode = 1;
    send_rsp(2'd2, 8'h00, SW'(32'hA0B1C2D3));
    send_rsp(2'd0, 8'h77, '0);
    t = 0;
    while (got_q.size() < 3 && t < 200) begin cycle(); t++; end
    rstn = 1'b0;
    #1;
    n_total++; if (tx_valid !== 1'b0 || fifo_level !== 3'd0 || tx_data !== 8'h00)
      $display("FAIL midreset_state: tx_valid=%b level=%0d data=%02h, required 0/0/00", tx_valid, fifo_level, tx_data); else n_pass++;
    repeat (2) cycle();
    rstn = 1'b1;
    got_q.delete(); exp_q.delete(); got_t.delete();
    repeat (20) cycle();
    n_total++; if (got_q.size() != 0 || tx_valid !== 1'b0)
      $display("FAIL midreset_residual: %0d bytes, tx_valid=%b, required 0/0", got_q.size(), tx_valid); else n_pass++;
  endtask

  initial begin
    rstn = 1'b0; rsp_valid = 1'b0; rsp_kind = 2'd0; rsp_arg = 8'h00; rsp_status = '0;
    err_valid = 1'b0; err_code = 8'h00; tx_ready = 1'b1;
    test_reset();
    test_ack();
    test_back_to_back();
    test_status_backpressure();
    test_full_drop();
    test_collision();
    test_nop_saturation();
    test_random();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
